// File: rtl/sici_pcs_syn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sici_pcs_syn_ctrl
// Purpose  : Receive-side PCS word alignment and frame synchronisation.
//            Hunts bit offsets of the raw deserializer stream until the 2-bit
//            sync header is valid, confirms lock over LCK_N consecutive valid
//            headers, then monitors windows of WIN_N headers and declares
//            loss when ERR_N of them are invalid.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Ck        in   clock
//   Rs        in   asynchronous reset, active low
//   CE        in   clock enable; every register holds while low
//   Raw_Dat_i in   unaligned word, bit FW-1 received first
//   PCS_Dat_o out  aligned word, sync header in [FW-1:FW-2]
//   Syn_OK    out  frame sync achieved
//   Lo_Syn    out  loss of sync, registered complement of Syn_OK
//   Slip_Pos  out  current alignment offset 0..FW-1
//   Slip      out  one-cycle pulse when Slip_Pos advances
//   Err_SH    out  one-cycle pulse per invalid header evaluated in SYNC
// ============================================================================
module sici_pcs_syn_ctrl #(
    parameter int FW    = 32,
    parameter int LCK_N = 32,
    parameter int WIN_N = 64,
    parameter int ERR_N = 16
) (
    input  logic                  Ck,
    input  logic                  Rs,
    input  logic                  CE,
    input  logic [FW-1:0]         Raw_Dat_i,
    output logic [FW-1:0]         PCS_Dat_o,
    output logic                  Syn_OK,
    output logic                  Lo_Syn,
    output logic [$clog2(FW)-1:0] Slip_Pos,
    output logic                  Slip,
    output logic                  Err_SH
);

    localparam int c_PW = $clog2(FW);
    localparam int c_IW = $clog2(2 * FW);
    localparam int c_LW = $clog2(LCK_N + 1);
    localparam int c_WW = $clog2(WIN_N + 1);
    localparam int c_EW = $clog2(ERR_N + 1);

    localparam logic [c_PW-1:0] c_POS_MAX = c_PW'(FW - 1);
    localparam logic [c_IW-1:0] c_WIN_MSB = c_IW'(2 * FW - 1);
    localparam logic [c_LW-1:0] c_LCK_N   = c_LW'(LCK_N);
    localparam logic [c_WW-1:0] c_WIN_N   = c_WW'(WIN_N);
    localparam logic [c_EW-1:0] c_ERR_N   = c_EW'(ERR_N);

    localparam logic [1:0] c_ST_HUNT    = 2'd0;
    localparam logic [1:0] c_ST_CONFIRM = 2'd1;
    localparam logic [1:0] c_ST_SYNC    = 2'd2;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [FW-1:0]   r_prev;
    logic [FW-1:0]   r_pcs_dat;
    logic [c_PW-1:0] r_slip_pos;
    logic            r_slip;
    logic            r_err_sh;
    logic            r_syn_ok;
    logic            r_lo_syn;
    logic            r_blank;
    logic [c_LW-1:0] r_lock_cnt;
    logic [c_WW-1:0] r_win_cnt;
    logic [c_EW-1:0] r_err_cnt;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [2*FW-1:0] w_win;
    logic [c_IW-1:0] w_msb;
    logic [FW-1:0]   w_aligned;
    logic            w_sh_ok;
    logic [c_LW-1:0] w_lock_inc;
    logic [c_WW-1:0] w_win_inc;
    logic [c_EW-1:0] w_err_inc;
    logic [1:0]      w_state_nxt;
    logic            w_slip_nxt;
    logic            w_err_sh_nxt;
    logic            w_blank_nxt;
    logic [c_LW-1:0] w_lock_nxt;
    logic [c_WW-1:0] w_win_nxt;
    logic [c_EW-1:0] w_errc_nxt;
    logic [c_PW-1:0] w_slip_pos_nxt;

    // Two-word window: the aligned word starts Slip_Pos bits into the
    // previous raw word and borrows the remainder from the current one.
    assign w_win     = {r_prev, Raw_Dat_i};
    assign w_msb     = c_WIN_MSB - c_IW'(r_slip_pos);
    assign w_aligned = w_win[w_msb -: FW];

    assign w_sh_ok    = r_pcs_dat[FW-1] ^ r_pcs_dat[FW-2];
    assign w_lock_inc = r_lock_cnt + c_LW'(1);
    assign w_win_inc  = r_win_cnt + c_WW'(1);
    assign w_err_inc  = r_err_cnt + c_EW'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Ck or negedge Rs) begin
        if (!Rs) begin
            r_state <= c_ST_HUNT;
        end else if (CE) begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A blanked cycle carries a word picked at the old
    // offset, so it never drives a transition.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (!r_blank) begin
            case (r_state)
                c_ST_HUNT: begin
                    if (w_sh_ok) begin
                        w_state_nxt = c_ST_CONFIRM;
                    end
                end
                c_ST_CONFIRM: begin
                    if (!w_sh_ok) begin
                        w_state_nxt = c_ST_HUNT;
                    end else if (w_lock_inc == c_LCK_N) begin
                        w_state_nxt = c_ST_SYNC;
                    end
                end
                c_ST_SYNC: begin
                    if (!w_sh_ok && (w_err_inc == c_ERR_N)) begin
                        w_state_nxt = c_ST_HUNT;
                    end
                end
                default: w_state_nxt = c_ST_HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_slip_nxt   = 1'b0;
        w_err_sh_nxt = 1'b0;
        w_blank_nxt  = 1'b0;
        w_lock_nxt   = r_lock_cnt;
        w_win_nxt    = r_win_cnt;
        w_errc_nxt   = r_err_cnt;
        if (!r_blank) begin
            case (r_state)
                c_ST_HUNT: begin
                    if (w_sh_ok) begin
                        w_lock_nxt = c_LW'(1);
                    end else begin
                        w_slip_nxt  = 1'b1;
                        w_blank_nxt = 1'b1;
                    end
                end
                c_ST_CONFIRM: begin
                    if (!w_sh_ok) begin
                        w_slip_nxt  = 1'b1;
                        w_blank_nxt = 1'b1;
                        w_lock_nxt  = '0;
                    end else if (w_lock_inc == c_LCK_N) begin
                        w_lock_nxt = '0;
                        w_win_nxt  = '0;
                        w_errc_nxt = '0;
                    end else begin
                        w_lock_nxt = w_lock_inc;
                    end
                end
                c_ST_SYNC: begin
                    w_err_sh_nxt = ~w_sh_ok;
                    // Loss outranks the window boundary; both clear counters.
                    // Loss keeps the offset: the next invalid header in HUNT
                    // is what slips.
                    if ((!w_sh_ok && (w_err_inc == c_ERR_N)) || (w_win_inc == c_WIN_N)) begin
                        w_win_nxt  = '0;
                        w_errc_nxt = '0;
                    end else begin
                        w_win_nxt = w_win_inc;
                        if (!w_sh_ok) begin
                            w_errc_nxt = w_err_inc;
                        end
                    end
                end
                default: begin
                    w_lock_nxt = '0;
                end
            endcase
        end
        w_slip_pos_nxt = r_slip_pos;
        if (w_slip_nxt) begin
            w_slip_pos_nxt = (r_slip_pos == c_POS_MAX) ? '0 : r_slip_pos + c_PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Datapath, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Ck or negedge Rs) begin
        if (!Rs) begin
            r_prev     <= '0;
            r_pcs_dat  <= '0;
            r_slip_pos <= '0;
            r_slip     <= 1'b0;
            r_err_sh   <= 1'b0;
            r_syn_ok   <= 1'b0;
            r_lo_syn   <= 1'b1;
            r_blank    <= 1'b0;
            r_lock_cnt <= '0;
            r_win_cnt  <= '0;
            r_err_cnt  <= '0;
        end else if (CE) begin
            r_prev     <= Raw_Dat_i;
            r_pcs_dat  <= w_aligned;
            r_slip_pos <= w_slip_pos_nxt;
            r_slip     <= w_slip_nxt;
            r_err_sh   <= w_err_sh_nxt;
            r_syn_ok   <= (w_state_nxt == c_ST_SYNC);
            r_lo_syn   <= (w_state_nxt != c_ST_SYNC);
            r_blank    <= w_blank_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_win_cnt  <= w_win_nxt;
            r_err_cnt  <= w_errc_nxt;
        end
    end

    assign PCS_Dat_o = r_pcs_dat;
    assign Syn_OK    = r_syn_ok;
    assign Lo_Syn    = r_lo_syn;
    assign Slip_Pos  = r_slip_pos;
    assign Slip      = r_slip;
    assign Err_SH    = r_err_sh;

endmodule
`default_nettype wire
